// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sample width, stereo sample type and pop FSM states
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_SCALE = 2'd2
  } pop_state_e;

endpackage

// File: rtl/audio_fifo_ram.sv
// rtl/audio_fifo_ram.sv - simple dual-port sample storage, synchronous read
module audio_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 48
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // A read and write to the same address in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - stereo sample FIFO popped on lrclk falling edge, with attenuation
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_l,
  input  logic [WIDTH-1:0]       in_r,
  input  logic                   lrclk,
  input  logic [2:0]             vol,
  output logic [WIDTH-1:0]       out_l,
  output logic [WIDTH-1:0]       out_r,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pop_state_e       state_q, state_d;
  logic             lrclk_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, raddr_q, raddr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic             underrun_q, underrun_d, overrun_q, overrun_d;
  logic             pop_req, push, pop, ram_re;
  logic [2*WIDTH-1:0] rd_data;

  assign pop_req  = lrclk_q & ~lrclk;
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = pop_req & (state_q == ST_IDLE) & (count_q != '0);

  always_comb begin
    state_d    = state_q;
    ram_re     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    raddr_d    = raddr_q;
    count_d    = count_q;
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    underrun_d = underrun_q | (pop_req & (state_q == ST_IDLE) & (count_q == '0));
    overrun_d  = overrun_q | (in_valid & ~in_ready);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    // The slot is released at the strobe; the pipeline reads from the latched address.
    if (pop) begin
      raddr_d  = rd_ptr_q;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_IDLE:  if (pop) state_d = ST_READ;
      ST_READ: begin
        ram_re  = 1'b1;
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        out_l_d = WIDTH'($signed(rd_data[2*WIDTH-1:WIDTH]) >>> vol);
        out_r_d = WIDTH'($signed(rd_data[WIDTH-1:0]) >>> vol);
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lrclk_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      raddr_q    <= '0;
      count_q    <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrclk_q    <= lrclk;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      raddr_q    <= raddr_d;
      count_q    <= count_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  audio_fifo_ram #(
    .DEPTH (DEPTH),
    .DW    (2*WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_l, in_r}),
    .re_i    (ram_re),
    .raddr_i (raddr_q),
    .rdata_o (rd_data)
  );

  assign out_l    = out_l_q;
  assign out_r    = out_r_q;
  assign level    = count_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter WIDTH, default 24, bits per channel sample.
REQ-003 SHALL have port clk  input  1  system clock; all logic single-domain, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer (game core) offers a stereo sample.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept; high when count < DEPTH.
REQ-007 SHALL have port in_l, in_r  input  WIDTH each  producer left/right samples, two's complement.
REQ-008 SHALL have port lrclk  input  1  frame clock from I2S controller, same clk domain.
REQ-009 SHALL have port vol  input  3  attenuation, arithmetic right-shift amount 0..7.
REQ-010 SHALL have port out_l, out_r  output  WIDTH each  held samples driven to I2S D_L_I/D_R_I.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port underrun, overrun  output  1 each  sticky error flags.

Function
REQ-013 Write: in_valid && in_ready at a rising clk edge SHALL push {in_l,in_r}; no push otherwise.
REQ-014 Overrun: in_valid while count==DEPTH SHALL drop the sample and set overrun; FIFO contents unchanged.
REQ-015 Frame strobe: SHALL register lrclk once; pop_req = previous lrclk 1 && current lrclk 0 (falling edge, start of left slot).
REQ-016 Pop: on pop_req with count>0, SHALL read head, apply attenuation, update out_l/out_r exactly 2 clk after the strobe cycle (1 RAM read + 1 scale stage).
REQ-017 Underrun: pop_req with count==0 SHALL hold out_l/out_r at previous values, set underrun, no pointer change.
REQ-018 Simultaneous push and pop in one cycle SHALL both occur; count unchanged; legal at count==DEPTH (in_ready stays low that cycle, so no push) and count==0 (pop treated as underrun, push still occurs).
REQ-019 Pointers SHALL be $clog2(DEPTH) bits, wrap modulo DEPTH; count tracked separately with range 0..DEPTH.
REQ-020 Attenuation SHALL be arithmetic (sign-preserving) right shift by vol, sampled in the scale stage; result width WIDTH, no rounding.
REQ-021 vol changes SHALL affect only samples popped after the change; held outputs are not rescaled.
REQ-022 Sticky flags SHALL clear only by reset.
REQ-023 level SHALL equal count, registered, updated the cycle after push/pop.
REQ-024 Control FSM states: IDLE (wait pop_req) -> READ (RAM address applied) -> SCALE (shift, load outputs) -> IDLE; pop_req arriving in READ/SCALE SHALL be ignored (frames are >>3 clk apart).

Reset
REQ-025 On rst_n low: pointers, count, level=0; out_l=out_r=0; underrun=overrun=0; FSM=IDLE; lrclk register=0; in_ready=1 after release.
REQ-026 Reset mid-operation SHALL abandon any in-flight pop; RAM contents need not clear.

Structure
REQ-027 Shared package audio_pkg SHALL hold WIDTH default, stereo sample struct {l,r}, and FSM state enum.
REQ-028 Storage SHALL be one sub-module audio_fifo_ram (simple dual-port, sync read, DEPTH x 2*WIDTH), inferable as distributed/BRAM.

Verification
REQ-029 Push 3 samples (L=0x000100,0x000200,0x000300), vol=0, toggle lrclk 3x -> out_l shows 0x000100,0x000200,0x000300 each 2 clk after falling edge; level 3->0.
REQ-030 Push 17 samples with DEPTH=16 and no pops -> in_ready low after 16th, 17th dropped, overrun=1, level=16.
REQ-031 Empty FIFO, lrclk falling edge -> out_l/out_r hold last value, underrun=1, level=0.
REQ-032 vol=3, pop L=0xFFF800 (-2048) -> out_l=0xFFFF00 (-256); pop L=0x000800 -> 0x000100.
REQ-033 level=16, same cycle push attempt and pop -> pop occurs, push dropped, overrun=1, level=15; level=0 with push+pop same cycle -> underrun=1, level=1.
REQ-034 Assert rst_n low during SCALE -> all outputs 0 immediately, no output update after release until next push+pop.
